led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pkg.sv | 23 ++
 rtl/tick_gen.sv | 52 +++++
 rtl/led_pattern_gen.sv | 139 +++++++++++++
 tb/tb_led_pattern_gen.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: pattern modes, bounce direction
// and the per-mode seed value loaded on a mode change.
package led_pkg;

  typedef enum logic [1:0] {
    COUNT   = 2'd0,
    ROTATE  = 2'd1,
    BOUNCE  = 2'd2,
    BREATHE = 2'd3
  } mode_e;

  // LEFT also means "duty ramping up" while breathing.
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  // Starting LED value of each mode; callers narrow it to the LED width.
  function automatic logic [31:0] mode_seed(input mode_e m);
    return ((m == ROTATE) || (m == BOUNCE)) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled and emits a one-cycle
// registered strobe on wrap.
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   en   - count enable; 0 holds the count and keeps tick low
//   clr  - synchronous clear of count and strobe (wins over en)
//   tick - registered one-cycle step strobe
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and strobe.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_TOP) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT, ROTATE, BOUNCE and BREATHE (PWM triangle)
// patterns advanced by a prescaled step strobe.
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   en   - run enable; 0 freezes prescaler and pattern state
//   mode - pattern select (led_pkg::mode_e encoding)
//   led  - registered LED drive, N_LEDS wide
//   tick - registered one-cycle step strobe
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led,
  output logic              tick
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  mode_e               mode_in_c;
  logic                mode_chg_c;
  logic                step_c;

  mode_e               mode_q, mode_d;
  dir_e                dir_q, dir_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  assign mode_in_c  = mode_e'(mode);
  assign mode_chg_c = (mode_in_c != mode_q);
  // A pending tick is only consumed while enabled.
  assign step_c     = tick & en;

  // A mode change restarts the prescaler so the new pattern gets a full period.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (mode_chg_c),
    .tick (tick)
  );

  // Next pattern state; a mode change overrides any coincident step.
  always_comb begin
    mode_d = mode_in_c;
    dir_d  = dir_q;
    led_d  = led_q;
    duty_d = duty_q;
    pwm_d  = pwm_q;
    if (en) begin
      pwm_d = pwm_q + PWM_BITS'(1);
    end
    if (mode_chg_c) begin
      led_d  = N_LEDS'(mode_seed(mode_in_c));
      dir_d  = LEFT;
      duty_d = '0;
      pwm_d  = '0;
    end else if (en) begin
      case (mode_q)
        COUNT: begin
          if (step_c) led_d = led_q + N_LEDS'(1);
        end
        ROTATE: begin
          if (step_c) led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
        end
        BOUNCE: begin
          if (step_c) begin
            // Turn around on the step that leaves an end, so ends never repeat.
            if (dir_q == LEFT) begin
              if (led_q[N_LEDS-1]) begin
                led_d = led_q >> 1;
                dir_d = RIGHT;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d = N_LEDS'(2);
                dir_d = LEFT;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
        end
        BREATHE: begin
          led_d = (pwm_q < duty_q) ? '1 : '0;
          if (step_c) begin
            // Triangle duty: dir LEFT ramps up, RIGHT ramps down.
            if (dir_q == LEFT) begin
              if (duty_q == DUTY_MAX) begin
                duty_d = duty_q - PWM_BITS'(1);
                dir_d  = RIGHT;
              end else begin
                duty_d = duty_q + PWM_BITS'(1);
              end
            end else begin
              if (duty_q == '0) begin
                duty_d = PWM_BITS'(1);
                dir_d  = LEFT;
              end else begin
                duty_d = duty_q - PWM_BITS'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= COUNT;
      dir_q  <= LEFT;
      led_q  <= '0;
      duty_q <= '0;
      pwm_q  <= '0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (N_LEDS=8, TICK_DIV=4, PWM_BITS=4).
// The stimulus process pushes the expected led/tick after each edge; a monitor
// pops one entry per cycle on the falling edge and compares.
module tb_led_pattern_gen;

  localparam int PH_RST = 0, PH_COUNT = 1, PH_MCHG = 2, PH_ROT = 3, PH_FRZ = 4,
                 PH_BNC = 5, PH_BRE = 6, PH_RSTMID = 7, PH_REL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] led;
  logic       tick;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .N_LEDS   (8),
    .TICK_DIV (4),
    .PWM_BITS (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .led  (led),
    .tick (tick)
  );

  typedef struct {
    logic [7:0] led;
    logic       tick;
    int         ph;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] rot_tab [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                               8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
  logic [7:0] bnc_tab [17] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                               8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                               8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  logic [7:0] tab [17];

  function automatic string ph_name(input int ph);
    case (ph)
      PH_RST:    return "reset";
      PH_COUNT:  return "count";
      PH_MCHG:   return "mode_change";
      PH_ROT:    return "rotate";
      PH_FRZ:    return "freeze";
      PH_BNC:    return "bounce";
      PH_BRE:    return "breathe";
      PH_RSTMID: return "reset_mid_bounce";
      default:   return "release_bounce";
    endcase
  endfunction

  // Expected breathe duty after k steps: 0..15..0 triangle, period 30.
  function automatic int duty_tri(input int k);
    int m;
    m = k % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  // Advance one edge with the current inputs and queue the expected outputs.
  task automatic expect_cyc(input logic [7:0] el, input logic et, input int ph, input int c);
    exp_t e;
    @(posedge clk);
    #1;
    e.led  = el;
    e.tick = et;
    e.ph   = ph;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Cycles c0..c1 after a prescaler restart: tick every 4th, table step after.
  task automatic run_tab(input int ph, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      expect_cyc(tab[(c - 1) / 4], (c % 4) == 0, ph, c);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (led !== e.led || tick !== e.tick) begin
          failures++;
          $display("FAIL %s cyc=%0d got led=%h tick=%b want led=%h tick=%b",
                   ph_name(e.ph), e.cyc, led, tick, e.led, e.tick);
        end
      end
    end
  end

  initial begin : stim
    rst  = 1'b0;
    en   = 1'b0;
    mode = 2'd0;
    expect_cyc(8'h00, 1'b0, PH_RST, 0);
    expect_cyc(8'h00, 1'b0, PH_RST, 1);

    checks++;
    if (led !== 8'h00 || tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got led=%h tick=%b want led=00 tick=0", led, tick);
    end

    // COUNT: wraps back to 00 after 256 steps; stop on a tick cycle at led=01.
    rst = 1'b1;
    en  = 1'b1;
    for (int c = 1; c <= 1032; c++) begin
      expect_cyc(8'((c - 1) / 4), (c % 4) == 0, PH_COUNT, c);
    end

    // Mode change on a tick cycle: step discarded, ROTATE seed loaded.
    mode = 2'd1;
    expect_cyc(8'h01, 1'b0, PH_MCHG, 0);
    for (int i = 0; i < 11; i++) tab[i] = rot_tab[i];
    run_tab(PH_ROT, 1, 38);
    en = 1'b0;
    for (int i = 1; i <= 10; i++) expect_cyc(8'h02, 1'b0, PH_FRZ, i);

    checks++;
    if (led !== 8'h02 || tick !== 1'b0) begin
      failures++;
      $display("FAIL freeze_expired got led=%h tick=%b want led=02 tick=0", led, tick);
    end

    en = 1'b1;
    run_tab(PH_ROT, 39, 44);

    // BOUNCE through both ends.
    mode = 2'd2;
    expect_cyc(8'h01, 1'b0, PH_MCHG, 0);
    for (int i = 0; i < 17; i++) tab[i] = bnc_tab[i];
    run_tab(PH_BNC, 1, 65);

    // BREATHE: led reflects previous pwm < previous duty.
    mode = 2'd3;
    expect_cyc(8'h00, 1'b0, PH_MCHG, 0);
    for (int c = 1; c <= 130; c++) begin
      expect_cyc((((c - 1) % 16) < duty_tri((c - 2) / 4)) ? 8'hFF : 8'h00,
                 (c % 4) == 0, PH_BRE, c);
    end

    // BOUNCE up to 20, reset mid-pattern, release with mode still BOUNCE.
    mode = 2'd2;
    expect_cyc(8'h01, 1'b0, PH_MCHG, 0);
    run_tab(PH_BNC, 1, 22);
    rst = 1'b0;
    expect_cyc(8'h00, 1'b0, PH_RSTMID, 0);
    rst = 1'b1;
    expect_cyc(8'h01, 1'b0, PH_REL, 0);
    run_tab(PH_REL, 1, 9);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
